vec_lane_sequencer: RTL and testbench

- Execute-stage controller for multi-lane vector instructions in the 5-stage pipeline.
- A vector op in E is held there while it is walked lane-by-lane through the shared ALU or memory port.
- The block generates F/D/E stall and flush controls, merging the load-use stall request and taken-branch flush into one priority-resolved set.

---
 rtl/vec_lane_sequencer.sv | 134 +++++++++++++
 tb/tb_vec_lane_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
// Execute-stage sequencer: walks a vector op in E lane-by-lane through the ALU or memory port.
// Latency: ALU op occupies E for LANES+2 cycles; memory op adds one cycle per MemAck wait.
// Backpressure: MemAck low holds the current lane indefinitely; stalls/flushes are merged here.
module vec_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              VecOpE,
    input  logic              MemOpE,
    input  logic              LdrStallD,
    input  logic              BranchTakenE,
    input  logic              MemAck,
    output logic              MemReq,
    output logic [LANE_W-1:0] LaneIdx,
    output logic              LaneValid,
    output logic              VecDone,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushE,
    output logic              FlushD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t            state_q, state_n;
    logic [LANE_W-1:0] lane_q, lane_n;
    logic              req_q, req_n;
    logic              lane_valid;
    logic              vec_done;
    logic              vec_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            lane_q  <= lane_n;
            req_q   <= req_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        lane_n     = lane_q;
        req_n      = req_q;
        lane_valid = 1'b0;
        vec_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                lane_n = '0;
                if (VecOpE) begin
                    if (MemOpE) begin
                        state_n = MEM;
                        req_n   = 1'b1;
                    end else begin
                        state_n = ALU;
                    end
                end
            end
            ALU: begin
                lane_valid = 1'b1;
                if (lane_q == LAST_LANE) begin
                    state_n = DONE;
                    lane_n  = '0;
                end else begin
                    lane_n = lane_q + 1'b1;
                end
            end
            MEM: begin
                // Lane retires only on an ack; request stays up back-to-back otherwise.
                if (MemAck) begin
                    lane_valid = 1'b1;
                    if (lane_q == LAST_LANE) begin
                        state_n = DONE;
                        req_n   = 1'b0;
                        lane_n  = '0;
                    end else begin
                        lane_n = lane_q + 1'b1;
                        req_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                vec_done = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
                lane_n  = '0;
                req_n   = 1'b0;
            end
        endcase
    end

    assign vec_stall = ((state_q == IDLE) && VecOpE) || (state_q == ALU) || (state_q == MEM);

    // Every output is forced low while reset is asserted, including the registered ones.
    always_comb begin
        MemReq    = 1'b0;
        LaneIdx   = '0;
        LaneValid = 1'b0;
        VecDone   = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushE    = 1'b0;
        FlushD    = 1'b0;
        if (!reset) begin
            MemReq    = req_q;
            LaneIdx   = lane_q;
            LaneValid = lane_valid;
            VecDone   = vec_done;
            StallE    = vec_stall;
            StallF    = vec_stall | LdrStallD;
            StallD    = vec_stall | LdrStallD;
            // A running vector op holds E rather than letting hazards bubble it.
            FlushE    = LdrStallD & ~vec_stall;
            FlushD    = BranchTakenE & ~vec_stall;
        end
    end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed bench for vec_lane_sequencer: output vector checked every step against hand-computed values.
module tb_vec_lane_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       VecOpE, MemOpE, LdrStallD, BranchTakenE, MemAck;
    logic       MemReq, LaneValid, VecDone;
    logic [1:0] LaneIdx;
    logic       StallF, StallD, StallE, FlushE, FlushD;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vec_lane_sequencer #(.LANES(4), .LANE_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .VecOpE       (VecOpE),
        .MemOpE       (MemOpE),
        .LdrStallD    (LdrStallD),
        .BranchTakenE (BranchTakenE),
        .MemAck       (MemAck),
        .MemReq       (MemReq),
        .LaneIdx      (LaneIdx),
        .LaneValid    (LaneValid),
        .VecDone      (VecDone),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .FlushD       (FlushD)
    );

    // Packed view: {MemReq, LaneIdx, LaneValid, VecDone, StallF, StallD, StallE, FlushE, FlushD}
    function automatic logic [9:0] ev(input logic mr, input logic [1:0] li, input logic lv,
                                      input logic vd, input logic sf, input logic sd,
                                      input logic se, input logic fe, input logic fd);
        return {mr, li, lv, vd, sf, sd, se, fe, fd};
    endfunction

    task automatic chk(input string tag, input logic [9:0] expv);
        logic [9:0] obs;
        #1;
        obs = {MemReq, LaneIdx, LaneValid, VecDone, StallF, StallD, StallE, FlushE, FlushD};
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic ld, input logic br, input logic ak);
        VecOpE = v; MemOpE = m; LdrStallD = ld; BranchTakenE = br; MemAck = ak;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("reset_idle", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 1, 1, 1, 1);
        chk("reset_masks_inputs", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("post_reset_idle", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        // ALU op with stray MemAck throughout
        cyc();
        drive(1, 0, 0, 0, 1);
        chk("alu_detect", ev(0, 2'd0, 0, 0, 1, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 1) drive(1, 0, 1, 1, 1);
            else        drive(1, 0, 0, 0, 1);
            chk($sformatf("alu_lane%0d", i), ev(0, 2'(i), 1, 0, 1, 1, 1, 0, 0));
        end
        cyc();
        drive(1, 0, 0, 0, 1);
        chk("alu_done", ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 0));
        cyc();
        drive(0, 0, 0, 0, 1);
        chk("alu_back_idle", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        // Load-use and branch with no vector op
        cyc();
        drive(0, 0, 1, 0, 0);
        chk("loaduse_only", ev(0, 2'd0, 0, 0, 1, 1, 0, 1, 0));
        drive(0, 0, 0, 1, 0);
        chk("branch_only", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
        drive(0, 0, 1, 1, 0);
        chk("loaduse_branch", ev(0, 2'd0, 0, 0, 1, 1, 0, 1, 1));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("idle_after_hazards", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        // Memory op: lane 1 ack delayed two cycles
        cyc();
        drive(1, 1, 0, 0, 0);
        chk("mem_detect", ev(0, 2'd0, 0, 0, 1, 1, 1, 0, 0));
        cyc();
        drive(1, 1, 0, 0, 1);
        chk("mem_lane0_ack", ev(1, 2'd0, 1, 0, 1, 1, 1, 0, 0));
        cyc();
        drive(1, 1, 0, 0, 0);
        chk("mem_lane1_wait1", ev(1, 2'd1, 0, 0, 1, 1, 1, 0, 0));
        cyc();
        chk("mem_lane1_wait2", ev(1, 2'd1, 0, 0, 1, 1, 1, 0, 0));
        cyc();
        drive(1, 1, 0, 0, 1);
        chk("mem_lane1_ack", ev(1, 2'd1, 1, 0, 1, 1, 1, 0, 0));
        cyc();
        chk("mem_lane2_ack", ev(1, 2'd2, 1, 0, 1, 1, 1, 0, 0));
        cyc();
        chk("mem_lane3_ack", ev(1, 2'd3, 1, 0, 1, 1, 1, 0, 0));
        cyc();
        drive(1, 1, 0, 0, 1);
        chk("mem_done", ev(0, 2'd0, 0, 1, 0, 0, 0, 0, 0));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("mem_back_idle", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in MEM at lane 2 with request outstanding
        cyc();
        drive(1, 1, 0, 0, 0);
        cyc();
        drive(1, 1, 0, 0, 1);
        cyc();
        drive(1, 1, 0, 0, 1);
        cyc();
        drive(1, 1, 0, 0, 0);
        chk("rst_pre_lane2", ev(1, 2'd2, 0, 0, 1, 1, 1, 0, 0));
        reset = 1'b1;
        drive(1, 1, 0, 0, 1);
        chk("rst_asserted", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        chk("rst_stray_ack", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("rst_still_idle", ev(0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
